// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared definitions for the universal shift register sequencing controller:
//   - cell select encodings driven on the shared 2-bit select bus
//   - command opcode enum
//   - controller state enum
//   - helper mapping a shift opcode onto its cell select code
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_SHR  = 2'b10;
    localparam logic [1:0] SEL_SHL  = 2'b11;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_SHR  = 2'b10,
        OP_SHL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Select code the cells need while a shift of the given direction runs.
    function automatic logic [1:0] shift_sel(input op_e op);
        logic [1:0] code;
        if (op == OP_SHL) begin
            code = SEL_SHL;
        end else begin
            code = SEL_SHR;
        end
        return code;
    endfunction

endpackage

// File: rtl/shift_cnt.sv
// -----------------------------------------------------------------------------
// shift_cnt
// Loadable down-counter holding the remaining shift steps of a command.
// A load value above WIDTH is clamped to WIDTH, since shifting a WIDTH-cell
// register further than its length cannot change the result.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (count -> 0)
//   load        capture clamped load_val
//   load_val    requested shift amount
//   dec         decrement by one (saturates at zero)
//   is_one      count equals one: the current step is the last one
// -----------------------------------------------------------------------------
module shift_cnt #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [AMT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    localparam logic [AMT_W-1:0] MAX_CNT = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] ONE_CNT = AMT_W'(1);

    logic [AMT_W-1:0] count_r;
    logic [AMT_W-1:0] clamp_s;

    // Clamp the requested amount to the register length.
    always_comb begin
        clamp_s = load_val;
        if (load_val > MAX_CNT) begin
            clamp_s = MAX_CNT;
        end else begin
            clamp_s = load_val;
        end
    end

    // Count register: load wins over decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {AMT_W{1'b0}};
        end else if (load) begin
            count_r <= clamp_s;
        end else if (dec && (count_r != {AMT_W{1'b0}})) begin
            count_r <= count_r - ONE_CNT;
        end
    end

    assign is_one = (count_r == ONE_CNT);

endmodule

// File: rtl/shift_ctrl.sv
// -----------------------------------------------------------------------------
// shift_ctrl
// Sequencing controller for a WIDTH-bit universal shift register built from
// 1-bit hold/load/shift cells sharing one 2-bit select bus. One command at a
// time is accepted over cmd_valid/cmd_ready; the controller then drives the
// select bus and the end-of-chain serial inputs and pulses done once.
//
// Optional feature macro: SHIFT_CTRL_ROTATE_EN
//   defined   : cmd_rot port exists; a shift with cmd_rot=1 recirculates the
//               bit leaving one end into the other end.
//   undefined : no cmd_rot port; shifts always fill with cmd_fill and
//               msb_q/lsb_q are unused.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake (ready only in IDLE)
//   cmd_op             00 NOP, 01 LOAD, 10 shift right, 11 shift left
//   cmd_amt            shift count (clamped to WIDTH)
//   cmd_fill           bit entering the vacated end
//   cmd_rot            rotate request (macro build only)
//   msb_q, lsb_q       end-cell outputs, used for rotation
//   sel                shared cell select (00 hold/01 load/10 right/11 left)
//   sr_in, sl_in       serial inputs of cell WIDTH-1 and cell 0
//   busy, done         command in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic             cmd_fill,
`ifdef SHIFT_CTRL_ROTATE_EN
    input  logic             cmd_rot,
`endif
    input  logic             msb_q,
    input  logic             lsb_q,
    output logic [1:0]       sel,
    output logic             sr_in,
    output logic             sl_in,
    output logic             busy,
    output logic             done
);

    state_e     state_r;
    state_e     state_s;
    op_e        op_r;
    op_e        dir_s;
    logic       fill_r;
    logic       accept_s;
    logic       cnt_load_s;
    logic       cnt_dec_s;
    logic       cnt_is_one_s;

    logic [1:0] sel_r;
    logic [1:0] sel_s;
    logic       busy_r;
    logic       busy_s;
    logic       done_r;
    logic       done_s;
    logic       ready_r;
    logic       ready_s;

    assign accept_s   = cmd_valid && ready_r;
    // Only shifts need a step count; NOP/LOAD leave the counter alone.
    assign cnt_load_s = accept_s && cmd_op[1];
    assign cnt_dec_s  = (state_r == ST_SHIFT);

    shift_cnt #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .load_val (cmd_amt),
        .dec      (cnt_dec_s),
        .is_one   (cnt_is_one_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op_e'(cmd_op))
                        OP_NOP:  state_s = ST_DONE;
                        OP_LOAD: state_s = ST_LOAD;
                        default: begin
                            if (cmd_amt == {AMT_W{1'b0}}) begin
                                state_s = ST_DONE;
                            end else begin
                                state_s = ST_SHIFT;
                            end
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_s = ST_DONE;
            ST_SHIFT: begin
                if (cnt_is_one_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Command field capture on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= OP_NOP;
            fill_r <= 1'b0;
        end else if (accept_s) begin
            op_r   <= op_e'(cmd_op);
            fill_r <= cmd_fill;
        end
    end

    // The outputs are registered from the next state, so the direction used
    // on the accepting edge must come from the opcode being captured.
    always_comb begin
        dir_s = op_r;
        if (accept_s) begin
            dir_s = op_e'(cmd_op);
        end else begin
            dir_s = op_r;
        end
    end

    // Output decode for the state about to be entered.
    always_comb begin
        sel_s   = SEL_HOLD;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        ready_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                ready_s = 1'b1;
            end
            ST_LOAD: begin
                sel_s  = SEL_LOAD;
                busy_s = 1'b1;
            end
            ST_SHIFT: begin
                sel_s  = shift_sel(dir_s);
                busy_s = 1'b1;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                sel_s = SEL_HOLD;
            end
        endcase
    end

    // Output registers; reset drops the select bus to hold immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r   <= SEL_HOLD;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            sel_r   <= sel_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ready_r <= ready_s;
        end
    end

    assign sel       = sel_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cmd_ready = ready_r;

`ifdef SHIFT_CTRL_ROTATE_EN
    logic rot_r;
    logic sr_in_s;
    logic sl_in_s;

    // Rotate request capture on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_r <= 1'b0;
        end else if (accept_s) begin
            rot_r <= cmd_rot;
        end
    end

    // During a rotating shift each end is fed from the opposite end cell.
    always_comb begin
        sr_in_s = fill_r;
        sl_in_s = fill_r;
        if (rot_r && (state_r == ST_SHIFT)) begin
            sr_in_s = lsb_q;
            sl_in_s = msb_q;
        end else begin
            sr_in_s = fill_r;
            sl_in_s = fill_r;
        end
    end

    assign sr_in = sr_in_s;
    assign sl_in = sl_in_s;
`else
    logic unused_s;

    assign sr_in    = fill_r;
    assign sl_in    = fill_r;
    assign unused_s = ^{msb_q, lsb_q};
`endif

endmodule

// File: tb/tb_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_ctrl
// Drives shift_ctrl (WIDTH = 8) chained to an array of 1-bit hold/load/shift
// cells and checks select timing, done/ready behaviour and register contents
// against a behavioural model of the shift commands.
// -----------------------------------------------------------------------------
module tb_shift_ctrl;

    localparam int W     = 8;
    localparam int AMT_W = $clog2(W + 1);

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [AMT_W-1:0] cmd_amt;
    logic             cmd_fill;
`ifdef SHIFT_CTRL_ROTATE_EN
    logic             cmd_rot;
`endif
    logic             msb_q;
    logic             lsb_q;
    logic [1:0]       sel;
    logic             sr_in;
    logic             sl_in;
    logic             busy;
    logic             done;

    logic [W-1:0]     q;
    logic [W-1:0]     par_in;
    logic [W-1:0]     ref_reg;

    int n_chk  = 0;
    int n_fail = 0;

    shift_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_fill  (cmd_fill),
`ifdef SHIFT_CTRL_ROTATE_EN
        .cmd_rot   (cmd_rot),
`endif
        .msb_q     (msb_q),
        .lsb_q     (lsb_q),
        .sel       (sel),
        .sr_in     (sr_in),
        .sl_in     (sl_in),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell array: cells are not reset and keep contents across a reset.
    for (genvar i = 0; i < W; i++) begin : g_cell
        logic right_src;
        logic left_src;
        if (i == W - 1) begin : g_top
            assign right_src = sr_in;
        end else begin : g_top
            assign right_src = q[i+1];
        end
        if (i == 0) begin : g_bot
            assign left_src = sl_in;
        end else begin : g_bot
            assign left_src = q[i-1];
        end
        always @(posedge clk) begin
            case (sel)
                2'b01:   q[i] <= par_in[i];
                2'b10:   q[i] <= right_src;
                2'b11:   q[i] <= left_src;
                default: q[i] <= q[i];
            endcase
        end
    end
    assign msb_q = q[W-1];
    assign lsb_q = q[0];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register contents after a command, from the arithmetic meaning of it.
    function automatic logic [W-1:0] model(input logic [W-1:0] v, input logic [1:0] op,
                                           input int amt, input logic fill,
                                           input logic rot, input logic [W-1:0] par);
        longint unsigned x;
        longint unsigned mask;
        int n;
        n    = (amt > W) ? W : amt;
        mask = (64'd1 << W) - 64'd1;
        x    = 64'(v);
        case (op)
            2'b01: x = 64'(par);
            2'b10: begin
                if (rot) begin
                    x = ((x >> n) | (x << (W - n))) & mask;
                end else begin
                    x = x >> n;
                    if (fill) x = x | (mask & ~(mask >> n));
                end
            end
            2'b11: begin
                if (rot) begin
                    x = ((x << n) | (x >> (W - n))) & mask;
                end else begin
                    x = (x << n) & mask;
                    if (fill) x = x | ((64'd1 << n) - 64'd1);
                end
            end
            default: x = x;
        endcase
        return x[W-1:0];
    endfunction

    // Issue one command from idle (called at a negedge) and check its timeline.
    task automatic run_cmd(input string tag, input logic [1:0] op, input int amt,
                           input logic fill, input logic rot, input logic [W-1:0] par);
        int k;
        int act_cnt;
        int bad_sel;
        int done_cnt;
        int done_cyc;
        int ready_cyc;
        int busy_cnt;
        logic [1:0] exp_sel;
        logic [W-1:0] exp_q;
        if (op == 2'b00)      k = 0;
        else if (op == 2'b01) k = 1;
        else                  k = (amt > W) ? W : amt;
        if (op == 2'b01)      exp_sel = 2'b01;
        else if (op == 2'b10) exp_sel = 2'b10;
        else                  exp_sel = 2'b11;
        exp_q = model(ref_reg, op, amt, fill, rot, par);

        check({tag, " ready_idle"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = AMT_W'(amt);
        cmd_fill  = fill;
`ifdef SHIFT_CTRL_ROTATE_EN
        cmd_rot   = rot;
`endif
        par_in    = par;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        act_cnt = 0; bad_sel = 0; done_cnt = 0; done_cyc = 0; ready_cyc = 0; busy_cnt = 0;
        for (int c = 1; c <= W + 4; c++) begin
            if (sel != 2'b00) begin
                act_cnt++;
                if (sel != exp_sel) bad_sel++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (busy === 1'b1) busy_cnt++;
            if (cmd_ready === 1'b1 && ready_cyc == 0) ready_cyc = c;
            @(negedge clk);
        end
        check({tag, " sel_cycles"}, 64'(act_cnt), 64'(k));
        check({tag, " sel_code"},   64'(bad_sel), 64'd0);
        check({tag, " done_count"}, 64'(done_cnt), 64'd1);
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(k + 1));
        check({tag, " ready_cycle"}, 64'(ready_cyc), 64'(k + 2));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(k + 1));
        check({tag, " result"},     64'(q), 64'(exp_q));
        ref_reg = exp_q;
    endtask

    logic [1:0] exp_sel_seq [8];
    logic       exp_done_seq[8];

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_amt   = '0;
        cmd_fill  = 1'b0;
`ifdef SHIFT_CTRL_ROTATE_EN
        cmd_rot   = 1'b0;
`endif
        par_in    = '0;
        ref_reg   = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst sel",   64'(sel),   64'd0);
        check("rst sr_in", 64'(sr_in), 64'd0);
        check("rst sl_in", 64'(sl_in), 64'd0);
        check("rst busy",  64'(busy),  64'd0);
        check("rst done",  64'(done),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst ready", 64'(cmd_ready), 64'd1);

        // Directed scenarios
        run_cmd("load_a5", 2'b01, 0, 1'b0, 1'b0, 8'hA5);
        check("load_a5 const", 64'(q), 64'hA5);
        run_cmd("shr3", 2'b10, 3, 1'b0, 1'b0, 8'h00);
        check("shr3 const", 64'(q), 64'h14);
        run_cmd("reload", 2'b01, 0, 1'b0, 1'b0, 8'hA5);
        run_cmd("shl12", 2'b11, 12, 1'b1, 1'b0, 8'h00);
        check("shl12 const", 64'(q), 64'hFF);
        run_cmd("load_5a", 2'b01, 0, 1'b0, 1'b0, 8'h5A);
        run_cmd("shr0", 2'b10, 0, 1'b1, 1'b0, 8'h00);
        run_cmd("nop", 2'b00, 5, 1'b1, 1'b0, 8'h00);
        check("hold const", 64'(q), 64'h5A);
        run_cmd("shr8", 2'b10, 8, 1'b1, 1'b0, 8'h00);
        check("shr8 const", 64'(q), 64'hFF);

`ifdef SHIFT_CTRL_ROTATE_EN
        run_cmd("load_81", 2'b01, 0, 1'b0, 1'b0, 8'h81);
        run_cmd("ror1", 2'b10, 1, 1'b0, 1'b1, 8'h00);
        check("ror1 const", 64'(q), 64'hC0);
        run_cmd("load_81b", 2'b01, 0, 1'b0, 1'b0, 8'h81);
        run_cmd("rol4", 2'b11, 4, 1'b0, 1'b1, 8'h00);
        check("rol4 const", 64'(q), 64'h18);
`endif

        // Reset pulsed during the second cycle of a 5-step shift
        run_cmd("load_pre_rst", 2'b01, 0, 1'b0, 1'b0, 8'hA5);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_amt = AMT_W'(5); cmd_fill = 1'b0;
`ifdef SHIFT_CTRL_ROTATE_EN
        cmd_rot = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort c1 sel", 64'(sel), 64'd2);
        @(negedge clk);
        check("abort c2 sel", 64'(sel), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("abort sel",  64'(sel),  64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int dn;
            int act;
            dn = 0; act = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (done === 1'b1) dn++;
                if (sel != 2'b00) act++;
            end
            check("abort no_done", 64'(dn), 64'd0);
            check("abort no_sel",  64'(act), 64'd0);
        end
        ref_reg = model(8'hA5, 2'b10, 1, 1'b0, 1'b0, 8'h00);
        check("abort partial", 64'(q), 64'(ref_reg));
        check("abort ready", 64'(cmd_ready), 64'd1);

        // Command held valid while busy is accepted only on leaving IDLE
        exp_sel_seq  = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        exp_done_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_amt = AMT_W'(3); cmd_fill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 2'b01; par_in = 8'h3C;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("b2b sel c%0d", c + 1), 64'(sel), 64'(exp_sel_seq[c]));
            check($sformatf("b2b done c%0d", c + 1), 64'(done), 64'(exp_done_seq[c]));
            if (c == 5) cmd_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b result", 64'(q), 64'h3C);
        ref_reg = 8'h3C;

        // Randomized commands against the model
        for (int t = 0; t < 40; t++) begin
            logic [1:0] r_op;
            int r_amt;
            logic r_fill;
            logic r_rot;
            logic [W-1:0] r_par;
            r_op   = 2'($urandom_range(0, 3));
            r_amt  = int'($urandom_range(0, 15));
            r_fill = 1'($urandom_range(0, 1));
`ifdef SHIFT_CTRL_ROTATE_EN
            r_rot  = 1'($urandom_range(0, 1));
`else
            r_rot  = 1'b0;
`endif
            r_par  = W'($urandom);
            run_cmd($sformatf("rnd%0d", t), r_op, r_amt, r_fill, r_rot, r_par);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Sequencing controller for a WIDTH-bit universal shift register built from 1-bit hold/load/shift cells sharing one 2-bit select bus. Accepts one command at a time over a valid/ready handshake and drives the shared select lines and end-of-chain serial inputs cycle by cycle. Sits between the command source and the cell array. Reports completion with a one-cycle done pulse.

## Interface
- WIDTH, 8: register length in cells; legal range 2 to 64.
- AMT_W, $clog2(WIDTH+1): width of the shift-amount field.
- clk  in  1  rising-edge clock, shared with the cell array.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 = NOP, 01 = LOAD, 10 = shift right, 11 = shift left.
- cmd_amt  in  AMT_W  shift count; ignored for LOAD and NOP.
- cmd_fill  in  1  bit shifted into the vacated end.
- cmd_rot  in  1  rotate instead of fill; exists only under the macro.
- msb_q  in  1  current output of cell WIDTH-1.
- lsb_q  in  1  current output of cell 0.
- sel  out  2  shared cell select: 00 hold, 01 load parallel input, 10 take right-shift input, 11 take left-shift input.
- sr_in  out  1  right-shift serial input of cell WIDTH-1.
- sl_in  out  1  left-shift serial input of cell 0.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: cmd_ready = 1, sel = 00.
  - LOAD: sel = 01.
  - SHIFT: sel = 10 for shift right, 11 for shift left.
  - DONE: sel = 00, done = 1.
- Acceptance: a command is accepted on a rising edge with cmd_valid && cmd_ready. On acceptance the controller registers op, amount, fill and rot.
- Transitions from IDLE on acceptance:
  - NOP goes to DONE.
  - LOAD goes to LOAD.
  - A shift with amount 0 goes to DONE.
  - Any other shift goes to SHIFT, with the count register set to min(cmd_amt, WIDTH).
- Other transitions:
  - LOAD goes to DONE.
  - SHIFT decrements the count each cycle and goes to DONE after the cycle in which the count equals 1.
  - DONE goes to IDLE.
- Amount handling:
  - cmd_amt greater than WIDTH is clamped to WIDTH.
  - A shift right by WIDTH leaves every cell equal to fill.
- Serial inputs without rotate: sr_in = sl_in = registered fill.
- Rotate (macro only): sr_in = lsb_q and sl_in = msb_q, applied combinationally every SHIFT cycle.
- Flow control:
  - cmd_ready is low in all states except IDLE.
  - cmd_valid seen while not ready is ignored. The source must hold its command until it is accepted.
- busy is high in LOAD, SHIFT and DONE.

## Timing
- Reset values: sel = 00, sr_in = 0, sl_in = 0, busy = 0, done = 0, cmd_ready = 1 once rst_n is released. State is IDLE and the count is 0.
- Reset asserted mid-command aborts immediately. The command is dropped and sel returns to hold asynchronously. Cells keep their partially shifted contents.
- Outputs sel, sr_in, sl_in and done are decoded from registered state only. There is no combinational path from the command inputs.
- Latency, counted from the accepting edge E0:
  - LOAD: sel = 01 during E0→E1, done during E1→E2, cmd_ready again after E2.
  - Shift by n (1 ≤ n ≤ WIDTH): sel active for exactly n cycles, done in cycle n+1, next acceptance possible at edge E(n+2).
  - NOP and amount 0: done in the cycle right after acceptance.
- Back-to-back: a command held valid through DONE is accepted on the edge leaving IDLE, at the earliest one cycle after done.

## Configuration
- SHIFT_CTRL_ROTATE_EN defined:
  - cmd_rot port exists.
  - When cmd_rot = 1 on a shift, the bit leaving one end re-enters at the other end.
- SHIFT_CTRL_ROTATE_EN undefined:
  - cmd_rot port is absent.
  - Shifts always fill with cmd_fill.
  - msb_q and lsb_q are unused but the ports remain.

## Structure
- Shared package shift_ctrl_pkg contains:
  - sel encodings SEL_HOLD, SEL_LOAD, SEL_SHR, SEL_SHL;
  - op enum OP_NOP, OP_LOAD, OP_SHR, OP_SHL;
  - state enum.
- One natural sub-module: shift_cnt, a loadable down-counter of width AMT_W with a clamp-on-load and an is_one flag.
- The bench instantiates WIDTH existing 1-bit cells chained to the controller.

## Test plan
All scenarios use WIDTH = 8.
- Reset then LOAD of parallel 0xA5 → sel = 01 for 1 cycle, done 1 cycle later, register = 0xA5, cmd_ready returns after 3 edges.
- 0xA5, shift right by 3 with fill 0 → exactly 3 cycles of sel = 10, result 0x14, done once.
- 0xA5, shift left by 12 with fill 1 → amount clamped, 8 shift cycles, result 0xFF.
- Shift by 0, and NOP → no non-hold sel cycle, done in the cycle after acceptance, register unchanged.
- With SHIFT_CTRL_ROTATE_EN: 0x81, rotate right by 1 → 0xC0; 0x81, rotate left by 4 → 0x18.
- rst_n pulsed low during cycle 2 of a 5-cycle shift → sel = 00 and busy = 0 immediately, no done pulse. A cmd_valid held during busy is not accepted until IDLE.
